// File: rtl/sca_sched.sv
// Loop scheduler for the sparse convolution accelerator: walks tile/cout/cin,
// fetches weight/index words, and hands one activation tile per pass to the SCA.
module sca_sched #(
    parameter int N_CIN         = 4,
    parameter int N_COUT        = 4,
    parameter int WEIGHT_ADDR_W = 12,
    parameter int INDEX_ADDR_W  = 10,
    parameter int MEM_LAT       = 2,
    parameter int TILE_W        = 16,
    parameter int TMO           = 64,
    localparam int CIN_W        = (N_CIN  > 1) ? $clog2(N_CIN)  : 1,
    localparam int COUT_W       = (N_COUT > 1) ? $clog2(N_COUT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [TILE_W-1:0]        num_tiles,
    input  logic [WEIGHT_ADDR_W-1:0] wbase,
    input  logic [INDEX_ADDR_W-1:0]  ibase,
    input  logic                     act_valid,
    output logic                     act_ready,
    output logic                     mem_rd_en,
    output logic [WEIGHT_ADDR_W-1:0] weight_addr,
    output logic [INDEX_ADDR_W-1:0]  index_addr,
    output logic                     sca_valid_in,
    input  logic                     sca_valid_out,
    output logic                     grp_last,
    output logic [CIN_W-1:0]         cin_idx,
    output logic [COUT_W-1:0]        cout_idx,
    output logic [TILE_W-1:0]        tile_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int TMO_W = $clog2(TMO + 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, ISSUE, WAIT_SCA, NEXT} state_t;

    state_t                     r_state, w_state_next;
    logic [CIN_W-1:0]           r_cin;
    logic [COUT_W-1:0]          r_cout;
    logic [TILE_W-1:0]          r_tile;
    logic [TILE_W-1:0]          r_ntiles;
    logic [WEIGHT_ADDR_W-1:0]   r_wbase;
    logic [INDEX_ADDR_W-1:0]    r_ibase;
    logic [LAT_W-1:0]           r_lat_cnt;
    logic [TMO_W-1:0]           r_tmo_cnt;
    logic                       r_done;
    logic                       r_err;
    logic                       w_done_next;
    logic                       w_err_set;
    logic                       w_last_pass;
    logic                       w_addr_en;
    logic [WEIGHT_ADDR_W-1:0]   w_woff;
    logic [INDEX_ADDR_W-1:0]    w_ioff;

    assign w_last_pass = (r_tile == r_ntiles - TILE_W'(1)) &&
                         (r_cout == COUT_W'(N_COUT - 1)) &&
                         (r_cin  == CIN_W'(N_CIN - 1));

    // Offsets wrap naturally at each memory's address width.
    assign w_woff = WEIGHT_ADDR_W'(r_cout) * WEIGHT_ADDR_W'(N_CIN) + WEIGHT_ADDR_W'(r_cin);
    assign w_ioff = INDEX_ADDR_W'(r_cout) * INDEX_ADDR_W'(N_CIN) + INDEX_ADDR_W'(r_cin);
    assign w_addr_en   = (r_state == FETCH) || (r_state == WAIT_MEM);
    assign weight_addr = w_addr_en ? (r_wbase + w_woff) : '0;
    assign index_addr  = w_addr_en ? (r_ibase + w_ioff) : '0;

    assign cin_idx  = r_cin;
    assign cout_idx = r_cout;
    assign tile_idx = r_tile;
    assign busy     = (r_state != IDLE);
    assign done     = r_done & ~abort;
    assign err      = r_err;

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        w_err_set    = 1'b0;
        mem_rd_en    = 1'b0;
        sca_valid_in = 1'b0;
        act_ready    = 1'b0;
        grp_last     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (num_tiles == '0) w_done_next  = 1'b1;
                    else                 w_state_next = FETCH;
                end
            end
            FETCH: begin
                mem_rd_en    = 1'b1;
                w_state_next = WAIT_MEM;
            end
            WAIT_MEM: begin
                if (r_lat_cnt == LAT_W'(MEM_LAT - 1)) w_state_next = ISSUE;
            end
            ISSUE: begin
                sca_valid_in = act_valid;
                act_ready    = act_valid;
                grp_last     = (r_cin == CIN_W'(N_CIN - 1)) && act_valid;
                if (act_valid) w_state_next = WAIT_SCA;
            end
            WAIT_SCA: begin
                if (sca_valid_out) begin
                    w_state_next = NEXT;
                end else if (r_tmo_cnt == TMO_W'(TMO - 1)) begin
                    w_state_next = IDLE;
                    w_err_set    = 1'b1;
                end
            end
            NEXT: begin
                if (w_last_pass) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_state_next = FETCH;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (abort) begin
            w_state_next = IDLE;
            w_done_next  = 1'b0;
            w_err_set    = 1'b0;
            mem_rd_en    = 1'b0;
            sca_valid_in = 1'b0;
            act_ready    = 1'b0;
            grp_last     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cin     <= '0;
            r_cout    <= '0;
            r_tile    <= '0;
            r_ntiles  <= '0;
            r_wbase   <= '0;
            r_ibase   <= '0;
            r_lat_cnt <= '0;
            r_tmo_cnt <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
            if (w_err_set) r_err <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (start && !abort && num_tiles != '0) begin
                        r_ntiles <= num_tiles;
                        r_wbase  <= wbase;
                        r_ibase  <= ibase;
                        r_err    <= 1'b0;
                    end
                end
                FETCH:    r_lat_cnt <= '0;
                WAIT_MEM: r_lat_cnt <= r_lat_cnt + LAT_W'(1);
                ISSUE:    r_tmo_cnt <= '0;
                WAIT_SCA: r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                NEXT: begin
                    if (r_cin == CIN_W'(N_CIN - 1)) begin
                        r_cin <= '0;
                        if (r_cout == COUT_W'(N_COUT - 1)) begin
                            r_cout <= '0;
                            r_tile <= r_tile + TILE_W'(1);
                        end else begin
                            r_cout <= r_cout + COUT_W'(1);
                        end
                    end else begin
                        r_cin <= r_cin + CIN_W'(1);
                    end
                end
                default: ;
            endcase
            // Every return to IDLE (finish, timeout, abort) leaves the loop position at zero.
            if (w_state_next == IDLE) begin
                r_cin     <= '0;
                r_cout    <= '0;
                r_tile    <= '0;
                r_lat_cnt <= '0;
                r_tmo_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sca_sched.sv
// Scoreboard bench for sca_sched with a 2x2 cin/cout tile and a fixed-latency SCA model.
module tb_sca_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_tiles = '0;
    logic [11:0] wbase = '0;
    logic [9:0]  ibase = '0;
    logic        act_valid = 1'b0;
    logic        act_ready;
    logic        mem_rd_en;
    logic [11:0] weight_addr;
    logic [9:0]  index_addr;
    logic        sca_valid_in;
    logic        sca_valid_out = 1'b0;
    logic        grp_last;
    logic [0:0]  cin_idx;
    logic [0:0]  cout_idx;
    logic [15:0] tile_idx;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;
    logic [63:0] addr_q[$];
    logic [63:0] launch_q[$];
    int          done_q[$];
    bit          resp_en = 1'b1;
    int          resp_cnt = 0;

    sca_sched #(
        .N_CIN(2), .N_COUT(2), .WEIGHT_ADDR_W(12), .INDEX_ADDR_W(10),
        .MEM_LAT(2), .TILE_W(16), .TMO(64)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_tiles(num_tiles), .wbase(wbase), .ibase(ibase),
        .act_valid(act_valid), .act_ready(act_ready),
        .mem_rd_en(mem_rd_en), .weight_addr(weight_addr), .index_addr(index_addr),
        .sca_valid_in(sca_valid_in), .sca_valid_out(sca_valid_out),
        .grp_last(grp_last), .cin_idx(cin_idx), .cout_idx(cout_idx), .tile_idx(tile_idx),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {16'h0, busy, done, err, mem_rd_en, sca_valid_in, act_ready, grp_last,
                weight_addr, index_addr, cin_idx, cout_idx, tile_idx};
    endfunction

    // SCA model: completion pulse three cycles after each launch.
    always @(negedge clk) begin
        if (sca_valid_out) sca_valid_out = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) sca_valid_out = 1'b1;
        end
        if (!rst && sca_valid_in && resp_en) resp_cnt = 3;
    end

    // Monitor: every strobe the DUT presents is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en) begin
                if (addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_rd unexpected waddr=%0h iaddr=%0h", weight_addr, index_addr);
                end else begin
                    chk("mem_addr", {42'h0, weight_addr, index_addr}, addr_q.pop_front());
                end
            end
            if (sca_valid_in) begin
                if (launch_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL launch unexpected cin=%0d cout=%0d tile=%0d", cin_idx, cout_idx, tile_idx);
                end else begin
                    chk("launch", {45'h0, act_ready, grp_last, cin_idx, cout_idx, tile_idx},
                        launch_q.pop_front());
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done unexpected pulse");
                end else begin
                    chk("done_pulse", 64'(done), 64'(done_q.pop_front()));
                end
            end
        end
    end

    task automatic push_pass(input int t, input int co, input int ci,
                             input logic [11:0] wb, input logic [9:0] ib);
        logic [11:0] wa;
        logic [9:0]  ia;
        logic        gl;
        wa = wb + 12'(co * 2 + ci);
        ia = ib + 10'(co * 2 + ci);
        gl = (ci == 1);
        addr_q.push_back({42'h0, wa, ia});
        launch_q.push_back({45'h0, 1'b1, gl, 1'(ci), 1'(co), 16'(t)});
    endtask

    task automatic push_job(input int nt, input logic [11:0] wb, input logic [9:0] ib);
        for (int t = 0; t < nt; t++)
            for (int co = 0; co < 2; co++)
                for (int ci = 0; ci < 2; ci++)
                    push_pass(t, co, ci, wb, ib);
        done_q.push_back(1);
    endtask

    task automatic do_start(input logic [15:0] nt, input logic [11:0] wb, input logic [9:0] ib);
        @(posedge clk); #1;
        start = 1'b1; num_tiles = nt; wbase = wb; ibase = ib;
        @(posedge clk); #1;
        start = 1'b0; num_tiles = '0; wbase = '0; ibase = '0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (k == budget) begin
            checks++; errors++;
            $display("FAIL %s timeout waiting for idle after %0d cycles", name, budget);
        end
    endtask

    task automatic wait_strobe(input string name, input bit want_mem);
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (want_mem ? mem_rd_en : sca_valid_in) break;
        end
        if (k == 50) begin
            checks++; errors++;
            $display("FAIL %s strobe never seen", name);
        end
    endtask

    task automatic settle_and_drain(input string name);
        repeat (3) @(negedge clk);
        chk({name, "_addr_left"},   64'(addr_q.size()),   64'd0);
        chk({name, "_launch_left"}, 64'(launch_q.size()), 64'd0);
        chk({name, "_done_left"},   64'(done_q.size()),   64'd0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("reset_outputs", all_outs(), 64'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_outputs", all_outs(), 64'h0);

        // Basic 4-pass job with address walk and grp_last on passes 2 and 4
        act_valid = 1'b1;
        push_job(1, 12'h100, 10'h020);
        do_start(16'd1, 12'h100, 10'h020);
        wait_idle("basic", 200);
        settle_and_drain("basic");
        chk("basic_err", 64'(err), 64'd0);

        // Zero-tile job: done next cycle, never busy
        done_q.push_back(1);
        do_start(16'd0, 12'h300, 10'h100);
        @(negedge clk);
        chk("zero_done", 64'({done, busy}), 64'b10);
        @(negedge clk);
        chk("zero_busy", 64'({done, busy}), 64'b00);
        settle_and_drain("zero");

        // Address wrap at 12/10 bits across two tiles
        push_job(2, 12'hFFE, 10'h3FE);
        do_start(16'd2, 12'hFFE, 10'h3FE);
        wait_idle("wrap", 400);
        settle_and_drain("wrap");

        // act_valid held low in ISSUE: no launch until it rises
        act_valid = 1'b0;
        push_job(1, 12'h010, 10'h010);
        do_start(16'd1, 12'h010, 10'h010);
        wait_strobe("stall_fetch", 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("stall_hold", 64'({busy, sca_valid_in, act_ready, grp_last}), 64'b1000);
        end
        @(posedge clk); #1 act_valid = 1'b1;
        @(negedge clk);
        chk("stall_release", 64'({sca_valid_in, act_ready}), 64'b11);
        wait_idle("stall", 200);
        settle_and_drain("stall");

        // SCA timeout: err after exactly 64 WAIT_SCA cycles, no done
        resp_en = 1'b0;
        push_pass(0, 0, 0, 12'h040, 10'h040);
        do_start(16'd1, 12'h040, 10'h040);
        wait_strobe("tmo_launch", 1'b0);
        repeat (64) @(negedge clk);
        chk("tmo_before", 64'({busy, err}), 64'b10);
        @(negedge clk);
        chk("tmo_after", 64'({busy, err, done}), 64'b010);
        settle_and_drain("tmo");
        resp_en = 1'b1;
        push_job(1, 12'h000, 10'h000);
        do_start(16'd1, 12'h000, 10'h000);
        @(negedge clk);
        chk("tmo_err_cleared", 64'({busy, err}), 64'b10);
        wait_idle("tmo_restart", 200);
        settle_and_drain("tmo_restart");

        // Abort during WAIT_MEM
        addr_q.push_back({42'h0, 12'h200, 10'h200});
        do_start(16'd1, 12'h200, 10'h200);
        wait_strobe("abort_fetch", 1'b1);
        @(posedge clk); #1 abort = 1'b1;
        @(negedge clk);
        chk("abort_cycle_strobes", 64'({mem_rd_en, sca_valid_in, act_ready, grp_last, done}), 64'd0);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_idle_outputs", all_outs(), 64'h0);
        settle_and_drain("abort");

        // Asynchronous reset mid-job, then a fresh job
        addr_q.push_back({42'h0, 12'h080, 10'h080});
        do_start(16'd3, 12'h080, 10'h080);
        wait_strobe("rst_fetch", 1'b1);
        #2 rst = 1'b1;
        #1 chk("rst_immediate", all_outs(), 64'h0);
        resp_cnt = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_released", all_outs(), 64'h0);
        push_job(1, 12'h500, 10'h150);
        do_start(16'd1, 12'h500, 10'h150);
        wait_idle("after_rst", 200);
        settle_and_drain("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
